gray_codec_pipe: RTL

Parametrised, pipelined binary/Gray code converter with valid/ready handshaking on both sides. It selects binary→Gray encode, Gray→binary decode, or decode with a Gray adjacency check on a per-word basis. It sits between a producer and consumer of counter or position words, such as pointer crossings and encoder readback, and supersedes the fixed 4-bit combinational converter. Two register stages give full throughput and lossless backpressure.

---
 rtl/gray_codec_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage pipelined binary/Gray converter with valid/ready
// handshakes on both sides. Each word carries its own mode:
//   00 encode, 01 decode, 10 decode + Gray adjacency check, 11 pass-through.
// Stage 1 captures the word, its mode and the adjacency verdict at accept time.
// Stage 2 holds the converted result presented on out_data/out_err.
module gray_codec_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_ENC  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_DEC  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_CHK  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_PASS = 2'b11;

    // Binary to Gray: each bit XORed with its more significant neighbour.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR from the MSB downwards.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 1 state
    logic              s1_valid;
    logic [WIDTH-1:0]  s1_data;
    logic [MODE_W-1:0] s1_mode;
    logic              s1_err;

    // Adjacency history for mode-10 words only
    logic [WIDTH-1:0]  prev_gray;
    logic              has_prev;

    // Handshake and datapath helpers
    logic              s2_ready;
    logic              accept;
    logic              s1_fire;
    logic [WIDTH-1:0]  diff_c;
    logic              dist_one_c;
    logic              chk_err_c;
    logic [WIDTH-1:0]  conv_c;

    // Ready chain: combinational from downstream state only, never from in_valid.
    always_comb begin
        s2_ready = !out_valid || out_ready;
        in_ready = !s1_valid || s2_ready;
        accept   = in_valid && in_ready;
        s1_fire  = s1_valid && s2_ready;
    end

    // Adjacency check: exactly one bit differs from the last mode-10 word.
    always_comb begin
        diff_c     = in_data ^ prev_gray;
        dist_one_c = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);
        chk_err_c  = (in_mode == MODE_CHK) && has_prev && !dist_one_c;
    end

    // Per-word conversion of the stage-1 contents.
    always_comb begin
        conv_c = s1_data;
        case (s1_mode)
            MODE_ENC:  conv_c = bin_to_gray(s1_data);
            MODE_DEC:  conv_c = gray_to_bin(s1_data);
            MODE_CHK:  conv_c = gray_to_bin(s1_data);
            MODE_PASS: conv_c = s1_data;
            default:   conv_c = s1_data;
        endcase
    end

    // Stage 1 register: load on accept, empty when forwarded without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_ENC;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_mode  <= in_mode;
            s1_err   <= chk_err_c;
        end else if (s1_fire) begin
            s1_valid <= 1'b0;
        end
    end

    // Adjacency history: only mode-10 accepts move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            has_prev  <= 1'b0;
        end else if (accept && (in_mode == MODE_CHK)) begin
            prev_gray <= in_data;
            has_prev  <= 1'b1;
        end
    end

    // Stage 2 register: load from stage 1, hold while stalled, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s1_fire) begin
            out_valid <= 1'b1;
            out_data  <= conv_c;
            out_err   <= s1_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
